// File: rtl/enc_pkg.sv
// Shared definitions for the active-low 4-to-2 sequential priority encoder.
// The optional ROUND_ROBIN_EN macro selects rotating priority in the top level.
package enc_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    // Index of the first set bit of req when the search starts at ptr and
    // wraps modulo NUM_LINES. Returns 0 when req is empty; callers only use
    // the result when at least one bit is set.
    function automatic logic [CODE_W-1:0] lowest_set_index(
        input logic [NUM_LINES-1:0] req,
        input logic [CODE_W-1:0]    ptr
    );
        logic [CODE_W-1:0] idx;
        logic [CODE_W-1:0] result;
        result = '0;
        // Walk from the farthest offset back to ptr so the nearest hit wins.
        for (int k = NUM_LINES - 1; k >= 0; k--) begin
            idx = ptr + CODE_W'(k);
            if (req[idx]) begin
                result = idx;
            end
        end
        return result;
    endfunction

    // True when more than one request bit is set.
    function automatic logic is_multi_hot(input logic [NUM_LINES-1:0] req);
        return |(req & (req - 1'b1));
    endfunction

endpackage

// File: rtl/sync_vec.sv
// N-stage, W-bit flop synchronizer with asynchronous active-low reset.
// Every stage resets to RST_VAL so downstream logic sees an idle vector.
module sync_vec #(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/active_low_4to2_encoder_seq.sv
// Registered 4-to-2 priority encoder with valid/ready handshake.
// Samples four active-low request lines through a synchronizer, encodes the
// winning index and holds it until accepted. Counts multi-hot captures.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority with
// index 0 highest.
module active_low_4to2_encoder_seq
    import enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [0:3]           y_n,
    input  logic                 ready,
    output logic [1:0]           w,
    output logic                 valid,
    output logic                 multi,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [NUM_LINES-1:0] y_line;
    logic [NUM_LINES-1:0] y_s;
    logic [NUM_LINES-1:0] req;
    logic                 cap;
    logic                 load;
    logic [CODE_W-1:0]    winner;
    logic                 multi_hot;
    logic [CODE_W-1:0]    ptr_cur;

    state_e               state_q, state_d;
    logic [CODE_W-1:0]    w_q, w_d;
    logic                 multi_q, multi_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    // Re-pack the ascending input port so bit i of y_line is line i.
    always_comb begin
        y_line = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            y_line[i] = y_n[i];
        end
    end

    sync_vec #(
        .STAGES  (SYNC_STAGES),
        .WIDTH   (NUM_LINES),
        .RST_VAL ({NUM_LINES{1'b1}})
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (y_line),
        .q_o   (y_s)
    );

    assign req       = ~y_s;
    assign cap       = en && (req != '0);
    assign load      = cap && ((state_q == ST_IDLE) || ready);
    assign winner    = lowest_set_index(req, ptr_cur);
    assign multi_hot = is_multi_hot(req);

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr_q, ptr_d;

    // After every capture the line just past the winner becomes top priority.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = winner + 1'b1;
        end
    end

    // Rotating priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_cur = ptr_q;
`else
    assign ptr_cur = '0;
`endif

    // Handshake FSM plus code/flag/counter next-state logic.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        multi_d = multi_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (ready && !cap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load) begin
            w_d     = winner;
            multi_d = multi_hot;
            if (multi_hot && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    // State and output registers; cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            multi_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            multi_q <= multi_d;
            err_q   <= err_d;
        end
    end

    assign w       = w_q;
    assign valid   = (state_q == ST_VALID);
    assign multi   = multi_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_active_low_4to2_encoder_seq.sv
// Self-checking bench for active_low_4to2_encoder_seq.
// Build with ROUND_ROBIN_EN defined to exercise rotating priority.
module tb_active_low_4to2_encoder_seq;

    localparam int SYNC    = 2;
    localparam int EW      = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          ready = 1'b0;
    logic [0:3]    y_n = 4'b1111;
    logic [1:0]    w;
    logic          valid;
    logic          multi;
    logic [EW-1:0] err_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    active_low_4to2_encoder_seq #(
        .SYNC_STAGES (SYNC),
        .ERR_CNT_W   (EW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .y_n     (y_n),
        .ready   (ready),
        .w       (w),
        .valid   (valid),
        .multi   (multi),
        .err_cnt (err_cnt)
    );

    // ---------------- behavioural reference model ----------------
    logic [3:0] mHist [SYNC];
    int   mValid = 0;
    int   mW = 0;
    int   mMulti = 0;
    int   mErr = 0;
    int   mPtr = 0;
    int   mReq;
    int   mCnt;
    int   mWin;
    bit   mTake;
    logic [3:0] yLine;

    function automatic int refWinner(input int reqMask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (((reqMask >> ((ptr + k) % 4)) & 1) == 1) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    always_comb begin
        yLine = 4'hF;
        for (int i = 0; i < 4; i++) yLine[i] = y_n[i];
    end

    always_comb begin
        mReq = 0;
        mCnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mHist[SYNC-1][i] == 1'b0) begin
                mReq = mReq | (1 << i);
                mCnt = mCnt + 1;
            end
        end
        mTake = en && (mCnt > 0) && ((mValid == 0) || ready);
        mWin  = refWinner(mReq, mPtr);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC; s++) mHist[s] <= 4'hF;
            mValid <= 0;
            mW     <= 0;
            mMulti <= 0;
            mErr   <= 0;
            mPtr   <= 0;
        end else begin
            if (mTake) begin
                mValid <= 1;
                mW     <= mWin;
                mMulti <= (mCnt > 1) ? 1 : 0;
                if (mCnt > 1 && mErr < ERR_MAX) mErr <= mErr + 1;
`ifdef ROUND_ROBIN_EN
                mPtr   <= (mWin + 1) % 4;
`endif
            end else if (mValid == 1 && ready) begin
                mValid <= 0;
            end
            mHist[0] <= yLine;
            for (int s = 1; s < SYNC; s++) mHist[s] <= mHist[s-1];
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [3:0] yn;
        int         expValid;
        int         expW;
        int         expMulti;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] yn, input logic enV, input logic rdy);
        y_n   = yn;
        en    = enV;
        ready = rdy;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t vecs [9];
    int   rrExp [5];

    initial begin
        vecs[0] = '{4'b1110, 1, 3, 0};
        vecs[1] = '{4'b1101, 1, 2, 0};
        vecs[2] = '{4'b1011, 1, 1, 0};
        vecs[3] = '{4'b0111, 1, 0, 0};
        vecs[4] = '{4'b0110, 1, 0, 1};
        vecs[5] = '{4'b1001, 1, 1, 1};
        vecs[6] = '{4'b1100, 1, 2, 1};
        vecs[7] = '{4'b0000, 1, 0, 1};
        vecs[8] = '{4'b1111, 0, 0, 0};
`ifdef ROUND_ROBIN_EN
        rrExp = '{0, 1, 2, 3, 0};
`else
        rrExp = '{0, 0, 0, 0, 0};
`endif

        // Reset held with all lines low: everything stays cleared.
        applyStimulus(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("rst_valid", valid, 0);
            checkOutput("rst_w", w, 0);
            checkOutput("rst_multi", multi, 0);
            checkOutput("rst_err", err_cnt, 0);
        end
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("idle_all_high_valid", valid, 0);
        end

        // Table: one capture per vector from a fresh reset, latency SYNC+1.
        for (int i = 0; i < 9; i++) begin
            pulseReset();
            applyStimulus(vecs[i].yn, 1'b1, 1'b0);
            tick();
            tick();
            checkOutput($sformatf("vec%0d_early_valid", i), valid, 0);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), valid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d_w", i), w, vecs[i].expW);
            checkOutput($sformatf("vec%0d_multi", i), multi, vecs[i].expMulti);
        end

        // Line 2 low then released with ready high: valid drops after sync.
        pulseReset();
        applyStimulus(4'b1101, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("l2_early_valid", valid, 0);
        tick();
        checkOutput("l2_valid", valid, 1);
        checkOutput("l2_w", w, 2);
        checkOutput("l2_multi", multi, 0);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("l2_release_still_valid", valid, 1);
        tick();
        checkOutput("l2_release_valid", valid, 0);
        checkOutput("l2_release_w_held", w, 2);

        // Multi-hot capture and error counter saturation.
        pulseReset();
        applyStimulus(4'b0110, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("mh_w", w, 0);
        checkOutput("mh_multi", multi, 1);
        checkOutput("mh_err_first", err_cnt, 1);
        for (int c = 0; c < 300; c++) tick();
        checkOutput("mh_err_sat", err_cnt, ERR_MAX);
        checkOutput("mh_valid", valid, 1);

        // Backpressure: code held while ready is low and input changes.
        pulseReset();
        applyStimulus(4'b1011, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("bp_first_w", w, 1);
        applyStimulus(4'b1110, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_hold_valid", valid, 1);
            checkOutput("bp_hold_w", w, 1);
        end
        ready = 1'b1;
        tick();
        checkOutput("bp_next_valid", valid, 1);
        checkOutput("bp_next_w", w, 3);
        checkOutput("bp_next_multi", multi, 0);

        // Enable low blocks captures; async reset clears a pending code.
        pulseReset();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("en_pre_err", err_cnt, 1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("en_off_drop", valid, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("en_off_valid", valid, 0);
        end
        checkOutput("en_off_err", err_cnt, 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        checkOutput("en_on_valid", valid, 1);
        checkOutput("en_on_err", err_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", valid, 0);
        checkOutput("async_rst_err", err_cnt, 0);
        checkOutput("async_rst_multi", multi, 0);
        tick();
        rst_n = 1'b1;

        // All lines low with ready high: priority sequence per build.
        pulseReset();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("prio_seq%0d_w", c), w, rrExp[c]);
            checkOutput($sformatf("prio_seq%0d_valid", c), valid, 1);
        end

        // Randomized traffic against the reference model.
        pulseReset();
        for (int c = 0; c < 500; c++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
            tick();
            checkOutput("rnd_valid", valid, mValid);
            checkOutput("rnd_w", w, mW);
            checkOutput("rnd_multi", multi, mMulti);
            checkOutput("rnd_err", err_cnt, mErr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/active_low_4to2_encoder_seq.md
Name: active_low_4to2_encoder_seq

Overview:
Registered 4-to-2 priority encoder with handshake. It is the reverse of the active-low 2-to-4 decoder with enable. It samples four active-low request lines, synchronises them, and encodes the winning line index to a 2-bit code. The code is presented with a valid/ready handshake and held stable until it is consumed. It also counts captures where more than one line was low, which the decoder can never produce legally.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on y_n; legal range 1..3
ERR_CNT_W, 8, width of the saturating multi-hot error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  active-high encode enable; gates new captures only
y_n  input  [0:3]  active-low request lines; y_n[0] is index 0, matching the decoder's output ordering
ready  input  1  consumer accepts the code this cycle
w  output  [1:0]  encoded index of the winning line
valid  output  1  w/multi hold a captured code
multi  output  1  captured vector had more than one line low
err_cnt  output  [ERR_CNT_W-1:0]  count of captures with multi=1

Behaviour:
- Reset (async assert, sync release): all synchronizer flops = 4'b1111 (inactive), state=IDLE, w=0, valid=0, multi=0, err_cnt=0. Outputs clear immediately on rst_n low, including mid-handshake.
- Synchronizer: y_n passes through SYNC_STAGES flops giving y_s. Request vector req = ~y_s; req bit i = line i low.
- cap = en && (req != 0).
- Fixed priority: lowest index wins. w = index of lowest set bit of req.
- multi = popcount(req) > 1.
- FSM, two states:
  - IDLE: valid=0. If cap, register w/multi and go to VALID; valid=1 on the next edge.
  - VALID: valid=1; w and multi are held stable while ready=0.
  - VALID with ready=1: handshake completes. If cap in the same cycle, reload w/multi and stay in VALID (back-to-back, one code per cycle). Otherwise go to IDLE; valid=0 next cycle.
- Latency: y_n edge to valid high = SYNC_STAGES+1 clocks. ready high to valid low = 1 clock.
- Capture is level-based: a line held low produces a new code on every accepted handshake.
- en low: no new captures. A pending valid stays asserted until accepted.
- ready while valid=0: ignored.
- err_cnt: increments by 1 on every capture (IDLE load or back-to-back reload) with multi-hot req. It saturates at all-ones and never wraps.
- All-high inputs: no capture, w unchanged.

Optional Feature:
ROUND_ROBIN_EN
- Defined: rotating priority. A 2-bit pointer ptr (reset 0) marks the highest-priority index. The search runs ptr, ptr+1, ... mod 4. After each capture, ptr = winning index + 1 mod 4 (wraps 3->0). multi and err_cnt behave as in the default build.
- Undefined: fixed priority, index 0 highest; no pointer flops.

Decomposition:
- Shared package enc_pkg holds:
  - NUM_LINES=4, CODE_W=2
  - state enum {ST_IDLE, ST_VALID}
  - function lowest_set_index(req, ptr)
- One sub-module: sync_vec, an N-stage, W-bit flop synchronizer with async active-low reset and a reset-value parameter, instantiated with width 4 and reset value all-ones.

Test Plan:
1. Reset: hold rst_n=0 with y_n=4'b0000, en=1 -> valid=0, w=0, multi=0, err_cnt=0 throughout. Release, then hold y_n=1111 -> valid stays 0.
2. en=1, ready=1, y_n=4'b1101 (line 2 low), SYNC_STAGES=2 -> valid=1 exactly 3 clocks later, w=2, multi=0. Then drive y_n=1111 -> valid=0 within 1 clock after the line's synchronised release.
3. y_n=4'b0110 (lines 0 and 3 low), ready=1 for 1 cycle -> w=0, multi=1, err_cnt=1. Hold y_n for 300 accepted cycles -> err_cnt saturates at 255.
4. Backpressure: capture line 1 (w=1), ready=0 for 5 clocks while y_n changes to 1110 -> w=1 and valid=1 held for all 5 clocks. Set ready=1 -> next code w=3.
5. en=0, y_n=4'b0000 for 10 clocks -> valid=0, err_cnt unchanged. Pulse rst_n low while in VALID -> valid=0 immediately.
6. ROUND_ROBIN_EN build: y_n=0000, ready=1 continuously -> w sequence 0,1,2,3,0. Default build with the same stimulus -> w=0 every cycle.
